// File: rtl/solve_ctrl_pkg.sv
// Shared types for the solve controller:
// response codes, controller states and a result classifier.
package sysdefs;

    typedef enum logic [1:0] {
        CODE_SAT      = 2'd0,
        CODE_UNSAT    = 2'd1,
        CODE_TIMEOUT  = 2'd2,
        CODE_CONFLICT = 2'd3
    } rsp_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int RCNT_W = 4;

    function automatic rsp_code_t classify(input logic sat, input logic unsat);
        if (sat && unsat) return CODE_CONFLICT;
        else if (sat) return CODE_SAT;
        else return CODE_UNSAT;
    endfunction

endpackage

// File: rtl/solve_ctrl_if.sv
// Host-side request/response handshake bundle.
// The host is the master; the controller is the slave.
interface solve_ctrl_if
    import sysdefs::*;
#(
    parameter int CYC_W = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [CYC_W-1:0] req_budget;
    logic             rsp_valid;
    logic             rsp_ready;
    rsp_code_t        rsp_code;
    logic [CYC_W-1:0] rsp_cycles;

    modport master (
        output req_valid, req_budget, rsp_ready,
        input  req_ready, rsp_valid, rsp_code, rsp_cycles
    );

    modport slave (
        input  req_valid, req_budget, rsp_ready,
        output req_ready, rsp_valid, rsp_code, rsp_cycles
    );
endinterface

// File: rtl/solve_ctrl_sat_counter.sv
// Saturating up-counter used to count RUN cycles.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CYC_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] value
);

    // count up while enabled, hold once all-ones is reached
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable && (value != '1)) begin
            value <= value + CYC_W'(1);
        end
    end

endmodule

// File: rtl/solve_ctrl.sv
// Solve controller: resets and starts a solver core,
// watches for a result or budget expiry and reports it.
module solve_ctrl
    import sysdefs::*;
#(
    parameter int CYC_W      = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    solve_ctrl_if.slave bus,
    output logic        solver_reset,
    output logic        solver_start,
    input  logic        solver_sat,
    input  logic        solver_unsat,
    output logic        busy
);

    state_t            state_q;
    state_t            state_d;
    rsp_code_t         code_q;
    rsp_code_t         code_d;
    logic [CYC_W-1:0]  budget_q;
    logic [CYC_W-1:0]  cycles_q;
    logic [CYC_W-1:0]  cnt;
    logic [CYC_W-1:0]  cnt_inc;
    logic [RCNT_W-1:0] rcnt_q;
    logic              accept;
    logic              finish;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              ready_d;
    logic              sreset_d;
    logic              start_d;
    logic              valid_d;
    logic              busy_d;

    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign finish  = (state_q == ST_RUN) && (state_d == ST_DONE);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CYC_W'(1);

    sat_counter #(
        .CYC_W (CYC_W)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q == ST_RUN),
        .value  (cnt)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state; a solver result beats budget expiry
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = ST_RST;
            end
            ST_RST: begin
                if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (solver_sat || solver_unsat) begin
                    state_d = ST_DONE;
                    code_d  = classify(solver_sat, solver_unsat);
                end else if ((budget_q != '0) && (cnt_inc == budget_q)) begin
                    state_d = ST_DONE;
                    code_d  = CODE_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // output decode from the upcoming state, registered below
    always_comb begin
        ready_d  = 1'b0;
        sreset_d = 1'b0;
        start_d  = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_RST:  sreset_d = 1'b1;
            ST_RUN:  start_d  = 1'b1;
            ST_DONE: valid_d  = 1'b1;
            default: busy_d   = 1'b0;
        endcase
    end

    // registered control outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ready_q  <= 1'b1;
            solver_reset <= 1'b1;
            solver_start <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req_ready_q  <= ready_d;
            solver_reset <= sreset_d;
            solver_start <= start_d;
            rsp_valid_q  <= valid_d;
            busy         <= busy_d;
        end
    end

    // budget capture, reset-hold counter and result latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            budget_q <= '0;
            rcnt_q   <= '0;
            code_q   <= CODE_SAT;
            cycles_q <= '0;
        end else begin
            if (accept) budget_q <= bus.req_budget;
            rcnt_q <= (state_q == ST_RST) ? rcnt_q + RCNT_W'(1) : '0;
            if (finish) begin
                code_q   <= code_d;
                cycles_q <= cnt_inc;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_code   = code_q;
    assign bus.rsp_cycles = cycles_q;

endmodule

// File: tb/tb_solve_ctrl.sv
// Randomized scoreboard bench for solve_ctrl.
// Expected outcomes come from a cycle-budget model of each solve.
module tb_solve_ctrl;
    import sysdefs::*;

    localparam int W    = 4;
    localparam int R    = 3;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int code;
        int cycles;
        int done;
    } exp_t;

    logic clock;
    logic reset;
    logic solver_reset;
    logic solver_start;
    logic solver_sat;
    logic solver_unsat;
    logic busy;

    int   edge_n;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];
    bit   mon_prev;
    exp_t mon_cur;

    solve_ctrl_if #(.CYC_W(W)) bus ();

    solve_ctrl #(
        .CYC_W      (W),
        .RST_CYCLES (R)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .solver_reset (solver_reset),
        .solver_start (solver_start),
        .solver_sat   (solver_sat),
        .solver_unsat (solver_unsat),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)",
                     name, act, req, edge_n);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
        chk({tag, "_sreset"}, int'(solver_reset), 1);
        chk({tag, "_start"}, int'(solver_start), 0);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_code"}, int'(bus.rsp_code), 0);
        chk({tag, "_rsp_cycles"}, int'(bus.rsp_cycles), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            solver_sat    = 1'($urandom_range(0, 1));
            solver_unsat  = 1'($urandom_range(0, 1));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            bus.req_valid = 1'b0;
            @(posedge clock); #1;
            chk("idle_req_ready", int'(bus.req_ready), 1);
            chk("idle_busy", int'(busy), 0);
            chk("idle_sreset", int'(solver_reset), 0);
            chk("idle_rsp_valid", int'(bus.rsp_valid), 0);
        end
        solver_sat    = 1'b0;
        solver_unsat  = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    // kind: 0 sat, 1 unsat, 2 both, 3 no answer; k = RUN cycle of answer
    task automatic run_txn(input int b, input int kind, input int k,
                           input int hold);
        exp_t e;
        int   acc;
        int   n;
        int   t;
        bit   wins;
        chk("pre_req_ready", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_budget = W'(b);
        @(posedge clock); #1;
        bus.req_budget = W'($urandom);
        acc  = edge_n;
        wins = (kind != 3) && (b == 0 || k <= b);
        n    = wins ? k : b;
        e.code   = !wins ? 2 : (kind == 2 ? 3 : kind);
        e.cycles = (n > MAXV) ? MAXV : n;
        e.done   = acc + R + n;
        exp_q.push_back(e);
        t = edge_n;
        while (t <= e.done + hold) begin
            if (t < acc + R) begin
                chk("rst_sreset", int'(solver_reset), 1);
                chk("rst_start", int'(solver_start), 0);
            end else if (t < e.done) begin
                chk("run_start", int'(solver_start), 1);
                chk("run_sreset", int'(solver_reset), 0);
            end
            if (wins && t == acc + R + k - 1) begin
                solver_sat   = (kind != 1);
                solver_unsat = (kind != 0);
            end else if (t < acc + R || t >= e.done) begin
                solver_sat   = 1'($urandom_range(0, 1));
                solver_unsat = 1'($urandom_range(0, 1));
            end else begin
                solver_sat   = 1'b0;
                solver_unsat = 1'b0;
            end
            bus.req_valid = 1'($urandom_range(0, 1));
            if (t == e.done + hold) bus.rsp_ready = 1'b1;
            else if (t < e.done) bus.rsp_ready = 1'($urandom_range(0, 1));
            else bus.rsp_ready = 1'b0;
            @(posedge clock); #1;
            t = edge_n;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        solver_sat    = 1'b0;
        solver_unsat  = 1'b0;
        chk("post_rsp_valid", int'(bus.rsp_valid), 0);
        chk("post_req_ready", int'(bus.req_ready), 1);
        chk("post_busy", int'(busy), 0);
        chk("post_sreset", int'(solver_reset), 0);
    endtask

    // start a solve with no answer and pull reset `at` edges later
    task automatic abort_txn(input int b, input int at);
        exp_t e;
        int   acc;
        bus.req_valid  = 1'b1;
        bus.req_budget = W'(b);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        acc = edge_n;
        if (b != 0 && at > R + b) begin
            e.code   = 2;
            e.cycles = b;
            e.done   = acc + R + b;
            exp_q.push_back(e);
        end
        while (edge_n < acc + at) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b0;
        #1 check_reset_vals("abort");
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_reset_vals("abort_hold");
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_rel_sreset", int'(solver_reset), 0);
        chk("abort_rel_req_ready", int'(bus.req_ready), 1);
        idle(20);
    endtask

    initial begin : monitor
        mon_prev = 1'b0;
        mon_cur  = '{0, 0, 0};
        forever begin
            @(negedge clock);
            if (bus.rsp_valid && !mon_prev) begin
                chk("rsp_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_cur = exp_q.pop_front();
                    chk("rsp_code", int'(bus.rsp_code), mon_cur.code);
                    chk("rsp_cycles", int'(bus.rsp_cycles), mon_cur.cycles);
                    chk("rsp_latency", edge_n, mon_cur.done);
                end
            end else if (bus.rsp_valid) begin
                chk("hold_code", int'(bus.rsp_code), mon_cur.code);
                chk("hold_cycles", int'(bus.rsp_cycles), mon_cur.cycles);
            end
            if (bus.rsp_valid) begin
                chk("done_start", int'(solver_start), 0);
                chk("done_sreset", int'(solver_reset), 0);
                chk("done_req_ready", int'(bus.req_ready), 0);
                chk("done_busy", int'(busy), 1);
            end
            mon_prev = bus.rsp_valid;
        end
    end

    initial begin : stim
        int b;
        int kind;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_budget = '0;
        bus.rsp_ready  = 1'b0;
        solver_sat     = 1'b0;
        solver_unsat   = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_vals("por");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("por_sreset_drop", int'(solver_reset), 0);
        idle(2);

        run_txn(0, 0, 10, 0);
        run_txn(5, 3, 1, 1);
        run_txn(5, 1, 5, 0);
        run_txn(0, 2, 3, 2);
        run_txn(7, 0, 2, 20);
        run_txn(0, 0, 1, 0);
        run_txn(15, 3, 1, 0);
        run_txn(0, 1, 20, 0);
        run_txn(1, 3, 1, 0);
        run_txn(4, 0, 5, 0);
        idle(1);

        abort_txn(0, R + 4);
        abort_txn(2, R + 5);

        for (int i = 0; i < 40; i++) begin
            b    = int'($urandom_range(0, MAXV));
            kind = int'($urandom_range(0, 3));
            if (kind == 3 && b == 0) b = int'($urandom_range(1, MAXV));
            run_txn(b, kind, int'($urandom_range(1, 18)),
                    int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)));
        end

        idle(5);
        chk("all_rsp_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/solve_ctrl.md
SOLVE_CTRL -- requirements
Module: solve_ctrl

Interface
REQ-001 Parameter CYC_W, default 32, sets the width of the cycle budget and cycle counter.
REQ-002 Parameter RST_CYCLES, default 2, sets the number of cycles solver_reset is held before a solve (range 1..15).
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 Port req_valid  input  1  host requests a solve.
REQ-006 Port req_ready  output  1  controller can accept a request.
REQ-007 Port req_budget  input  CYC_W  maximum RUN cycles; 0 means unlimited; sampled on request acceptance.
REQ-008 Port solver_reset  output  1  active-high synchronous reset to the solver core.
REQ-009 Port solver_start  output  1  level start to the solver core.
REQ-010 Port solver_sat  input  1  solver reports satisfiable.
REQ-011 Port solver_unsat  input  1  solver reports unsatisfiable.
REQ-012 Port rsp_valid  output  1  result available.
REQ-013 Port rsp_ready  input  1  host consumes result.
REQ-014 Port rsp_code  output  2  0 SAT, 1 UNSAT, 2 TIMEOUT, 3 CONFLICT.
REQ-015 Port rsp_cycles  output  CYC_W  RUN cycles consumed, saturating at all-ones.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, RST, RUN, DONE; encoding is free.
REQ-018 IDLE: req_ready=1; req_valid=1 at an edge accepts the request, latches req_budget, clears the counter, enters RST.
REQ-019 RST: solver_reset=1 for exactly RST_CYCLES consecutive cycles, solver_start=0, then RUN.
REQ-020 RUN: solver_start=1 continuously, solver_reset=0; counter increments by 1 each RUN cycle, saturating at 2^CYC_W-1.
REQ-021 RUN, solver_sat=1 and solver_unsat=0 at an edge: latch code SAT, enter DONE.
REQ-022 RUN, solver_unsat=1 and solver_sat=0: latch code UNSAT, enter DONE.
REQ-023 RUN, both high in the same cycle: latch code CONFLICT, enter DONE.
REQ-024 RUN, no result and budget!=0 and counter+1==budget at that edge: latch code TIMEOUT, enter DONE.
REQ-025 A solver result in the same cycle as budget exhaustion takes priority over TIMEOUT.
REQ-026 rsp_cycles equals the number of RUN cycles, including the detecting cycle (first RUN cycle result -> 1).
REQ-027 DONE: rsp_valid=1; rsp_code/rsp_cycles stable until handshake; solver_start=0, solver_reset=0.
REQ-028 DONE with rsp_ready=1 at an edge: return to IDLE; rsp_valid falls next cycle.
REQ-029 req_ready=0 outside IDLE; req_valid outside IDLE is ignored, not queued.
REQ-030 solver_sat/unsat are ignored outside RUN.
REQ-031 Result-to-rsp_valid latency: exactly 1 cycle after the detecting edge.

Reset
REQ-032 On reset low: state IDLE, req_ready=1, solver_reset=1, solver_start=0, rsp_valid=0, rsp_code=0, rsp_cycles=0, busy=0, counter and budget cleared.
REQ-033 After reset release, solver_reset SHALL drop to 0 on the first clock edge in IDLE.
REQ-034 Reset asserted mid-RUN or mid-DONE aborts the solve; no response is produced.

Structure
REQ-035 The rsp_code enum (SAT/UNSAT/TIMEOUT/CONFLICT) and the state enum SHALL be in the shared package sysdefs.
REQ-036 The saturating cycle counter SHALL be a sub-module sat_counter (CYC_W, clear, enable, value).
REQ-037 All outputs SHALL be registered; no combinational path from solver inputs to outputs.

Verification
REQ-038 Request budget=0, solver_sat after 10 RUN cycles -> rsp_code=0, rsp_cycles=10, rsp_valid 1 cycle after sat.
REQ-039 Request budget=5, solver never responds -> rsp_code=2, rsp_cycles=5, solver_start=0 in DONE.
REQ-040 Budget=5, solver_unsat on the 5th RUN cycle -> rsp_code=1 (result beats timeout), rsp_cycles=5.
REQ-041 solver_sat and solver_unsat both high on the 3rd RUN cycle -> rsp_code=3, rsp_cycles=3.
REQ-042 rsp_ready held 0 for 20 cycles in DONE -> outputs stable; second req_valid ignored until return to IDLE.
REQ-043 reset low mid-RUN -> all outputs at reset values immediately (asynchronous); no rsp_valid after release.
